// File: rtl/control_unit.sv
// k_and_s_pkg: instruction decode type shared by the K&S 16-bit processor blocks.
// control_unit: multi-cycle Moore sequencer driving data_path control strobes.
//   clk, rst_n            clock (rising edge) / async active-low reset
//   decoded_instruction   current IR decode
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow       registered ALU flags, sampled in BR_COND
//   branch, pc_enable     PC load select / PC update strobe
//   ir_enable             IR load strobe
//   addr_sel              0: RAM address = PC, 1: operand address
//   c_sel                 write-back source, 0: ALU, 1: data_in
//   operation             ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
//   write_reg_enable      register-file write strobe
//   flags_reg_enable      flag-register capture strobe
//   ram_write_enable      RAM write strobe
//   halt                  processor halted
//   instr_count           saturating retired-instruction counter
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNEG   = 4'd10,
        I_BOV    = 4'd11,
        I_BNNEG  = 4'd12,
        I_BNZERO = 4'd13,
        I_HALT   = 4'd14
    } decoded_instruction_type;

endpackage

module control_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter bit          BOV_SIGNED = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [CNT_W-1:0]        instr_count
);

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_LOAD_1    = 4'd3,
        S_LOAD_2    = 4'd4,
        S_STORE_1   = 4'd5,
        S_STORE_2   = 4'd6,
        S_MOVE      = 4'd7,
        S_ALU       = 4'd8,
        S_BR_UNCOND = 4'd9,
        S_BR_COND   = 4'd10,
        S_HALT      = 4'd11
    } state_t;

    state_t                  state, state_nxt;
    decoded_instruction_type op_q;
    logic                    bov_flag;
    logic                    cond_c;

    // State register, opcode latch and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            op_q        <= I_NOP;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                op_q <= decoded_instruction;
                if (instr_count != {CNT_W{1'b1}}) begin
                    instr_count <= instr_count + CNT_W'(1);
                end
            end
        end
    end

    assign bov_flag = BOV_SIGNED ? signed_overflow : unsigned_overflow;

    // Branch condition for the opcode latched in DECODE
    always_comb begin
        cond_c = 1'b0;
        case (op_q)
            I_BZERO:  cond_c = zero_op;
            I_BNEG:   cond_c = neg_op;
            I_BOV:    cond_c = bov_flag;
            I_BNNEG:  cond_c = !neg_op;
            I_BNZERO: cond_c = !zero_op;
            default:  cond_c = 1'b0;
        endcase
    end

    // Next-state and Moore output decode
    always_comb begin
        state_nxt        = S_INIT;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        case (state)
            S_INIT: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_enable = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                pc_enable = 1'b1;
                case (decoded_instruction)
                    I_LOAD:   state_nxt = S_LOAD_1;
                    I_STORE:  state_nxt = S_STORE_1;
                    I_MOVE:   state_nxt = S_MOVE;
                    I_ADD, I_SUB, I_AND, I_OR:
                              state_nxt = S_ALU;
                    I_BRANCH: state_nxt = S_BR_UNCOND;
                    I_BZERO, I_BNEG, I_BOV, I_BNNEG, I_BNZERO:
                              state_nxt = S_BR_COND;
                    I_HALT:   state_nxt = S_HALT;
                    default:  state_nxt = S_FETCH;
                endcase
            end
            S_LOAD_1: begin
                addr_sel  = 1'b1;
                c_sel     = 1'b1;
                state_nxt = S_LOAD_2;
            end
            S_LOAD_2: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                state_nxt        = S_FETCH;
            end
            S_STORE_1: begin
                addr_sel  = 1'b1;
                state_nxt = S_STORE_2;
            end
            S_STORE_2: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                state_nxt        = S_FETCH;
            end
            S_MOVE: begin
                // OR of the source with itself copies it through the ALU
                operation        = 2'b11;
                write_reg_enable = 1'b1;
                state_nxt        = S_FETCH;
            end
            S_ALU: begin
                case (op_q)
                    I_SUB:   operation = 2'b01;
                    I_AND:   operation = 2'b10;
                    I_OR:    operation = 2'b11;
                    default: operation = 2'b00;
                endcase
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
                state_nxt        = S_FETCH;
            end
            S_BR_UNCOND: begin
                branch    = 1'b1;
                pc_enable = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BR_COND: begin
                branch    = cond_c;
                pc_enable = cond_c;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halt      = 1'b1;
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: two instances share stimulus, one with
// default parameters and one with CNT_W=2 / BOV_SIGNED=0.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    decoded_instruction_type di;
    logic                    zf, nf, uf, sf;

    logic        br_m, pc_m, ir_m, as_m, cs_m, wr_m, fl_m, rw_m, h_m;
    logic [1:0]  op_m;
    logic [15:0] cnt_out_m;
    logic        br_s, pc_s, ir_s, as_s, cs_s, wr_s, fl_s, rw_s, h_s;
    logic [1:0]  op_s;
    logic [1:0]  cnt_out_s;

    int errors = 0;
    int checks = 0;
    int cnt_m  = 0;
    int cnt_s  = 0;

    always #5 clk = ~clk;

    control_unit dut_m (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(di),
        .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(sf),
        .branch(br_m), .pc_enable(pc_m), .ir_enable(ir_m), .addr_sel(as_m),
        .c_sel(cs_m), .operation(op_m), .write_reg_enable(wr_m),
        .flags_reg_enable(fl_m), .ram_write_enable(rw_m), .halt(h_m),
        .instr_count(cnt_out_m)
    );

    control_unit #(.CNT_W(2), .BOV_SIGNED(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(di),
        .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(sf),
        .branch(br_s), .pc_enable(pc_s), .ir_enable(ir_s), .addr_sel(as_s),
        .c_sel(cs_s), .operation(op_s), .write_reg_enable(wr_s),
        .flags_reg_enable(fl_s), .ram_write_enable(rw_s), .halt(h_s),
        .instr_count(cnt_out_s)
    );

    wire [10:0] w_m = {br_m, pc_m, ir_m, as_m, cs_m, op_m, wr_m, fl_m, rw_m, h_m};
    wire [10:0] w_s = {br_s, pc_s, ir_s, as_s, cs_s, op_s, wr_s, fl_s, rw_s, h_s};

    // Cycles per instruction, FETCH and DECODE included
    function automatic int cycles(input decoded_instruction_type op);
        case (op)
            I_LOAD, I_STORE: return 4;
            I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH,
            I_BZERO, I_BNEG, I_BOV, I_BNNEG, I_BNZERO, I_HALT: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected control word for cycle k of an instruction
    function automatic logic [10:0] exp_word(input decoded_instruction_type op, input int k,
                                             input logic z, input logic n, input logic u,
                                             input logic s, input bit bov_s);
        logic b, pc, ir, as, cs, wr, fl, rw, h, t;
        logic [1:0] o;
        {b, pc, ir, as, cs, wr, fl, rw, h, t} = '0;
        o = 2'b00;
        if (k == 0) begin
            ir = 1'b1;
        end else if (k == 1) begin
            pc = 1'b1;
        end else begin
            case (op)
                I_LOAD:   begin as = 1'b1; cs = 1'b1; wr = (k == 3); end
                I_STORE:  begin as = 1'b1; rw = (k == 3); end
                I_MOVE:   begin o = 2'd3; wr = 1'b1; end
                I_ADD, I_SUB, I_AND, I_OR: begin
                    o  = 2'(int'(op) - int'(I_ADD));
                    wr = 1'b1;
                    fl = 1'b1;
                end
                I_BRANCH: begin b = 1'b1; pc = 1'b1; end
                I_BZERO, I_BNEG, I_BOV, I_BNNEG, I_BNZERO: begin
                    if (op == I_BZERO)  t = z;
                    if (op == I_BNEG)   t = n;
                    if (op == I_BOV)    t = bov_s ? s : u;
                    if (op == I_BNNEG)  t = !n;
                    if (op == I_BNZERO) t = !z;
                    b  = t;
                    pc = t;
                end
                I_HALT:   h = 1'b1;
                default:  ;
            endcase
        end
        return {b, pc, ir, as, cs, o, wr, fl, rw, h};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input string name, input logic [10:0] em, input logic [10:0] es);
        chk({name, " ctrl(main)"},  32'(w_m), 32'(em));
        chk({name, " ctrl(small)"}, 32'(w_s), 32'(es));
        chk({name, " count(main)"},  32'(cnt_out_m), 32'(cnt_m));
        chk({name, " count(small)"}, 32'(cnt_out_s), 32'(cnt_s));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic decoded_instruction_type rand_instr();
        return decoded_instruction_type'(4'($urandom_range(0, 15)));
    endfunction

    // Runs one instruction; caller sits at posedge+1 with state FETCH
    task automatic run_instr(input decoded_instruction_type op, input bit rand_flags,
                             output logic br2_m, output logic br2_s);
        int nc;
        nc    = cycles(op);
        br2_m = 1'b0;
        br2_s = 1'b0;
        for (int k = 0; k < nc; k++) begin
            di = (k == 1) ? op : rand_instr();
            if (rand_flags) {zf, nf, uf, sf} = 4'($urandom);
            @(negedge clk);
            check_cycle($sformatf("op%0d k%0d", op, k),
                        exp_word(op, k, zf, nf, uf, sf, 1'b1),
                        exp_word(op, k, zf, nf, uf, sf, 1'b0));
            if (k == 2) begin
                br2_m = br_m;
                br2_s = br_s;
            end
            if (k == 1) begin
                if (cnt_m < 65535) cnt_m++;
                if (cnt_s < 3) cnt_s++;
            end
            next_cycle();
        end
    endtask

    // Holds reset for two cycles, releases it and checks the INIT cycle
    task automatic do_reset();
        rst_n = 1'b0;
        di    = I_NOP;
        cnt_m = 0;
        cnt_s = 0;
        repeat (2) begin
            @(negedge clk);
            check_cycle("reset", 11'd0, 11'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_cycle("init", 11'd0, 11'd0);
        next_cycle();
    endtask

    typedef struct {
        decoded_instruction_type op;
        logic z, n, u, s;
        logic take_m;
        logic take_s;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic bm, bs;
        decoded_instruction_type op;

        tbl[0]  = '{I_ADD,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{I_SUB,    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{I_AND,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{I_OR,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{I_MOVE,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{I_LOAD,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{I_STORE,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{I_BRANCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{I_BZERO,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{I_BZERO,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{I_BOV,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{I_BOV,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{I_BNEG,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{I_BNNEG,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{I_BNZERO, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{decoded_instruction_type'(4'hF), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        {zf, nf, uf, sf} = 4'b0000;
        do_reset();

        // NOP stream: the 2-bit counter saturates at 3
        repeat (5) run_instr(I_NOP, 1'b1, bm, bs);
        chk("count sat(small)", 32'(cnt_out_s), 32'd3);

        // Table-driven opcode coverage with flags held steady
        for (int i = 0; i < 17; i++) begin
            {zf, nf, uf, sf} = {tbl[i].z, tbl[i].n, tbl[i].u, tbl[i].s};
            run_instr(tbl[i].op, 1'b0, bm, bs);
            if (cycles(tbl[i].op) >= 3) begin
                chk($sformatf("tbl%0d take(main)", i),  32'(bm), 32'(tbl[i].take_m));
                chk($sformatf("tbl%0d take(small)", i), 32'(bs), 32'(tbl[i].take_s));
            end
        end

        // Random instruction stream against the reference model
        repeat (300) begin
            do op = rand_instr(); while (op == I_HALT);
            run_instr(op, 1'b1, bm, bs);
        end

        // HALT absorbs; counters frozen; reset restarts
        run_instr(I_HALT, 1'b1, bm, bs);
        repeat (6) begin
            di = rand_instr();
            {zf, nf, uf, sf} = 4'($urandom);
            @(negedge clk);
            check_cycle("halted", 11'd1, 11'd1);
            next_cycle();
        end
        do_reset();
        run_instr(I_ADD, 1'b1, bm, bs);

        // Async reset during STORE_1: no write may follow
        di = I_NOP;
        @(negedge clk);
        check_cycle("st fetch", exp_word(I_STORE, 0, zf, nf, uf, sf, 1'b1),
                    exp_word(I_STORE, 0, zf, nf, uf, sf, 1'b0));
        next_cycle();
        di = I_STORE;
        @(negedge clk);
        check_cycle("st decode", exp_word(I_STORE, 1, zf, nf, uf, sf, 1'b1),
                    exp_word(I_STORE, 1, zf, nf, uf, sf, 1'b0));
        if (cnt_m < 65535) cnt_m++;
        if (cnt_s < 3) cnt_s++;
        next_cycle();
        di = I_NOP;
        @(negedge clk);
        check_cycle("st store1", exp_word(I_STORE, 2, zf, nf, uf, sf, 1'b1),
                    exp_word(I_STORE, 2, zf, nf, uf, sf, 1'b0));
        #1;
        rst_n = 1'b0;
        cnt_m = 0;
        cnt_s = 0;
        #1;
        check_cycle("st async rst", 11'd0, 11'd0);
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            chk("st no write(main)",  32'(rw_m), 32'd0);
            chk("st no write(small)", 32'(rw_s), 32'd0);
        end
        do_reset();
        run_instr(I_STORE, 1'b1, bm, bs);
        run_instr(I_NOP, 1'b1, bm, bs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle Moore FSM sequencing the K&S 16-bit processor. Sits directly upstream of data_path. Consumes decoded_instruction and the four registered flags. Drives every data_path control strobe plus the RAM write strobe, a halt indicator and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter
BOV_SIGNED, 1, 1: BOV tests signed_overflow; 0: BOV tests unsigned_overflow

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
decoded_instruction  input  decoded_instruction_type (k_and_s_pkg)  current IR decode
zero_op  input  1  registered zero flag
neg_op  input  1  registered negative flag
unsigned_overflow  input  1  registered unsigned overflow flag
signed_overflow  input  1  registered signed overflow flag
branch  output  1  PC loads mem_addr instead of PC+1
pc_enable  output  1  PC update strobe
ir_enable  output  1  IR load strobe
addr_sel  output  1  0: ram_addr=PC, 1: ram_addr=operand address
c_sel  output  1  0: write-back from ALU, 1: from data_in
operation  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
write_reg_enable  output  1  register-file write strobe
flags_reg_enable  output  1  flag-register capture strobe
ram_write_enable  output  1  RAM write strobe, data = data_out
halt  output  1  processor halted
instr_count  output  CNT_W  retired instructions, saturating

Behaviour:
- Reset is asynchronous, active-low. During reset: state=INIT, instr_count=0.
- All control outputs are pure functions of state, except branch and pc_enable in BR_COND. Default for every output is 0 unless listed below.
- INIT: all outputs 0. Next state FETCH unconditionally, so FETCH begins 1 cycle after rst_n rises.
- FETCH: addr_sel=0, ir_enable=1. Next state DECODE.
- DECODE: pc_enable=1, branch=0 (PC<=PC+1). instr_count increments, saturating at all-ones. Next state by decoded_instruction:
  - LOAD -> LOAD_1
  - STORE -> STORE_1
  - MOVE -> MOVE
  - ADD/SUB/AND/OR -> ALU
  - BRANCH -> BR_UNCOND
  - BZERO/BNEG/BOV/BNNEG/BNZERO -> BR_COND
  - HALT -> HALT
  - NOP or any other value -> FETCH
- LOAD_1: addr_sel=1, c_sel=1 (RAM address setup). Next state LOAD_2.
- LOAD_2: addr_sel=1, c_sel=1, write_reg_enable=1. Next state FETCH.
- STORE_1: addr_sel=1. Next state STORE_2.
- STORE_2: addr_sel=1, ram_write_enable=1. Next state FETCH.
- MOVE: operation=11 (OR of a source register with itself), c_sel=0, write_reg_enable=1, flags_reg_enable=0. Next state FETCH.
- ALU: operation = ADD 00 / SUB 01 / AND 10 / OR 11, from decoded_instruction latched in DECODE. c_sel=0, write_reg_enable=1, flags_reg_enable=1. Next state FETCH.
- BR_UNCOND: branch=1, pc_enable=1. Next state FETCH.
- BR_COND: condition is zero_op (BZERO), neg_op (BNEG), selected overflow flag (BOV), !neg_op (BNNEG), !zero_op (BNZERO). Opcode is latched in DECODE. branch and pc_enable both equal the condition. Next state FETCH.
- HALT: halt=1. Absorbing state; only reset exits. instr_count is frozen.
- Cycles per instruction (including FETCH and DECODE): LOAD/STORE 4; ALU/MOVE/branches 3; NOP 2.
- Flags are sampled in BR_COND, i.e. flags written by the prior ALU instruction.
- Opcode latch is a register loaded in DECODE. Reset value I_NOP.
- decoded_instruction changes outside DECODE are ignored.
- Reset asserted mid-instruction: immediate return to INIT, all strobes 0 in the same cycle (asynchronous), no partial write completes afterward.
- One-hot or binary encoding is free. Unreachable states recover to INIT.

Test Plan:
- Reset release with decoded_instruction=I_NOP -> INIT 1 cycle, then FETCH(ir_enable=1)/DECODE(pc_enable=1) alternating; instr_count 0->1->2 each DECODE.
- I_ADD in DECODE -> next cycle operation=00, write_reg_enable=1, flags_reg_enable=1, c_sel=0; 3 cycles total. Repeat for SUB=01, AND=10, OR=11.
- I_LOAD -> LOAD_1 addr_sel=1, c_sel=1, write_reg_enable=0; LOAD_2 write_reg_enable=1. I_STORE -> ram_write_enable=1 only in 4th cycle with addr_sel=1.
- I_BZERO with zero_op=1 -> branch=1, pc_enable=1 in 3rd cycle; with zero_op=0 -> both 0. I_BOV with signed_overflow=1, unsigned_overflow=0 and BOV_SIGNED=1 -> taken; with BOV_SIGNED=0 -> not taken.
- I_HALT -> halt=1 permanently, all strobes 0, instr_count frozen; then rst_n pulse -> halt=0, instr_count=0, restart at INIT.
- CNT_W=2, run 5 NOPs -> instr_count 1,2,3,3,3. Assert rst_n low during STORE_1 -> ram_write_enable never pulses.
